// File: rtl/regfiletmp_ctrl.sv
// regfiletmp_ctrl
//   Allocation, write-port arbitration and in-order retirement controller for
//   the temporary (speculative) register file. Entries are allocated in
//   circular order, dispatch and two completion sources share the file's
//   single write port, the head entry retires once its speculative value is
//   valid, and a misprediction flush clears the file in one cycle.
//
// Ports
//   clock, reset               rising-edge clock, async active-low reset
//   disp_*                     dispatch request / allocation handshake
//   cmp0_*, cmp1_*             completion sources (tag, data, handshake)
//   rf_data_in, rf_waddr       write port data/address
//   rf_new_entry               full-entry write strobe (dispatch)
//   rf_update_entry            spec_data/spec_valid write strobe (completion)
//   rf_rd_addr1, rf_data_out1  head entry read port
//   rf_flush                   clear the temporary register file
//   cmt_*                      retirement to the architectural file
//   flush_req                  misprediction flush request
//   count, full, empty         occupancy
//
// Entry layout: {rd[72:68], pc[67:36], type[35:34], spec_data[33:2],
//                spec_valid[1], valid[0]}
module regfiletmp_ctrl #(
  parameter int DEPTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             disp_req,
  input  logic [4:0]       disp_rd,
  input  logic [31:0]      disp_pc,
  input  logic [1:0]       disp_type,
  output logic             disp_ack,
  output logic [TAG_W-1:0] disp_tag,
  input  logic             cmp0_req,
  input  logic [TAG_W-1:0] cmp0_tag,
  input  logic [31:0]      cmp0_data,
  output logic             cmp0_ack,
  input  logic             cmp1_req,
  input  logic [TAG_W-1:0] cmp1_tag,
  input  logic [31:0]      cmp1_data,
  output logic             cmp1_ack,
  output logic [72:0]      rf_data_in,
  output logic [TAG_W-1:0] rf_waddr,
  output logic             rf_new_entry,
  output logic             rf_update_entry,
  output logic [TAG_W-1:0] rf_rd_addr1,
  input  logic [72:0]      rf_data_out1,
  output logic             rf_flush,
  output logic             cmt_valid,
  output logic [4:0]       cmt_rd,
  output logic [31:0]      cmt_data,
  output logic [31:0]      cmt_pc,
  input  logic             cmt_ready,
  input  logic             flush_req,
  output logic [TAG_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam int CNT_W = TAG_W + 1;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [TAG_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  logic             rr_q;          // favoured completion source when both request

  logic             run_active;
  logic             cmp_any, cmp_sel, cmp_grant, disp_grant;
  logic [TAG_W-1:0] cmp_tag, tag_off;
  logic [31:0]      cmp_data;
  logic             in_flight, head_ready, retire;
  logic             unused_type;

  assign unused_type = ^rf_data_out1[35:34];

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // Grant decode: completions win over dispatch; a flush request or reset
  // suppresses every grant in the cycle it is seen.
  assign run_active = reset && (state_q == RUN) && !flush_req;
  assign cmp_any    = cmp0_req | cmp1_req;
  assign cmp_sel    = (cmp0_req && cmp1_req) ? rr_q : cmp1_req;
  assign cmp_grant  = run_active && cmp_any;
  assign disp_grant = run_active && !cmp_any && disp_req && !full;

  assign cmp_tag  = cmp_sel ? cmp1_tag  : cmp0_tag;
  assign cmp_data = cmp_sel ? cmp1_data : cmp0_data;

  // Offset from head wraps modulo DEPTH, so a single compare covers the
  // wrapped occupied window.
  assign tag_off   = cmp_tag - head_q;
  assign in_flight = ({1'b0, tag_off} < count_q);

  assign head_ready = !empty && rf_data_out1[0] && rf_data_out1[1];
  assign retire     = run_active && head_ready && cmt_ready;

  // State register and pointers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == RUN && flush_req) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (disp_grant) tail_q <= tail_q + 1'b1;
        if (retire)     head_q <= head_q + 1'b1;
        count_q <= count_q + CNT_W'(disp_grant) - CNT_W'(retire);
      end
      // A dropped (not in flight) completion still counts as the grant.
      if (cmp_grant) rr_q <= ~cmp_sel;
    end
  end

  // Next-state logic: a flush lasts exactly one cycle; a request seen
  // while already flushing is absorbed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (flush_req) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Output logic
  always_comb begin
    disp_ack        = disp_grant;
    disp_tag        = tail_q;
    cmp0_ack        = cmp_grant && !cmp_sel;
    cmp1_ack        = cmp_grant && cmp_sel;
    rf_new_entry    = disp_grant;
    rf_update_entry = cmp_grant && in_flight;
    rf_waddr        = '0;
    rf_data_in      = '0;
    if (disp_grant) begin
      rf_waddr   = tail_q;
      rf_data_in = {disp_rd, disp_pc, disp_type, 32'h0, 1'b0, 1'b1};
    end else if (cmp_grant && in_flight) begin
      rf_waddr   = cmp_tag;
      rf_data_in = {39'h0, cmp_data, 1'b1, 1'b0};
    end
    rf_rd_addr1 = head_q;
    rf_flush    = (state_q == FLUSH);
    cmt_valid   = run_active && head_ready;
    cmt_rd      = rf_data_out1[72:68];
    cmt_pc      = rf_data_out1[67:36];
    cmt_data    = rf_data_out1[33:2];
  end

endmodule
